// File: rtl/io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : io_pkg                                                     |
// | Purpose : Shared read-address decode for io_read_mux. Classifies a   |
// |           read address as channel / status / invalid (status word    |
// |           sits at address R) and validates the select width.        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package io_pkg;

  typedef enum logic [1:0] {
    SEL_CHAN    = 2'd0,
    SEL_STATUS  = 2'd1,
    SEL_INVALID = 2'd2
  } sel_kind_e;

  // The status word lives immediately above the last channel.
  function automatic int unsigned status_addr(input int unsigned r);
    return r;
  endfunction

  // The select field must be able to address every channel plus status.
  function automatic bit sel_width_ok(input int unsigned r, input int unsigned n);
    return int'(n) >= $clog2(r + 1);
  endfunction

  function automatic sel_kind_e decode_sel(input int unsigned sel, input int unsigned r);
    if (sel < status_addr(r)) begin
      return SEL_CHAN;
    end else if (sel == status_addr(r)) begin
      return SEL_STATUS;
    end else begin
      return SEL_INVALID;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_read_mux_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : io_read_mux_if                                           |
// | Purpose   : Bundles the channel inputs, read request and read        |
// |             response / flag outputs of io_read_mux.                  |
// | Ports     : data_in, in_valid, rd_req, rd_sel  (master -> slave)     |
// |             rd_data, rd_valid, rd_ack, rd_err, pending, overrun      |
// |             (slave -> master)                                        |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface io_read_mux_if #(
  parameter int unsigned R = 4,
  parameter int unsigned T = 8,
  parameter int unsigned N = 3
);
  logic [R*T-1:0] data_in;
  logic [R-1:0]   in_valid;
  logic           rd_req;
  logic [N-1:0]   rd_sel;
  logic [T-1:0]   rd_data;
  logic           rd_valid;
  logic [R-1:0]   rd_ack;
  logic           rd_err;
  logic [R-1:0]   pending;
  logic [R-1:0]   overrun;

  modport master (
    output data_in, in_valid, rd_req, rd_sel,
    input  rd_data, rd_valid, rd_ack, rd_err, pending, overrun
  );

  modport slave (
    input  data_in, in_valid, rd_req, rd_sel,
    output rd_data, rd_valid, rd_ack, rd_err, pending, overrun
  );
endinterface
`default_nettype wire

// File: rtl/io_chan_hold.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : io_chan_hold                                               |
// | Purpose : Per-channel hold register with sticky pending / overrun.   |
// | Ports   : clk, rst_n    clock, async active-low reset                |
// |           in_valid      capture data_in this edge                    |
// |           data_in[T]    channel sample                               |
// |           rd_hit        this channel is being read this edge         |
// |           hold_q[T]     captured sample                              |
// |           pending_q     unread data present                          |
// |           overrun_q     a sample was overwritten before being read   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module io_chan_hold #(
  parameter int unsigned T = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [T-1:0] data_in,
  input  logic         rd_hit,
  output logic [T-1:0] hold_q,
  output logic         pending_q,
  output logic         overrun_q
);
  import io_pkg::*;

  logic [T-1:0] hold_d;
  logic         pending_d;
  logic         overrun_d;

  always_comb begin
    hold_d    = in_valid ? data_in : hold_q;
    // A new sample beats a simultaneous read: the reader got the old value,
    // so the new one is still unread.
    pending_d = in_valid ? 1'b1 : (rd_hit ? 1'b0 : pending_q);
    // A read always clears overrun; only an unread overwrite sets it.
    if (rd_hit) begin
      overrun_d = 1'b0;
    end else if (in_valid && pending_q) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_read_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : io_read_mux                                                |
// | Purpose : R-channel capture-and-read multiplexer. Each channel holds |
// |           its latest sample with sticky pending/overrun flags; a     |
// |           read returns a channel, the pending status word (address   |
// |           R) or an error, one cycle after the request.               |
// | Ports   : clk, rst_n   clock, async active-low reset                 |
// |           bus          io_read_mux_if.slave (data_in, in_valid,      |
// |                        rd_req, rd_sel in; rd_data, rd_valid, rd_ack, |
// |                        rd_err, pending, overrun out)                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module io_read_mux #(
  parameter int unsigned R = 4,
  parameter int unsigned T = 8,
  parameter int unsigned N = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  io_read_mux_if.slave  bus
);
  import io_pkg::*;

  if (!sel_width_ok(R, N)) begin : g_sel_width_check
    $error("io_read_mux: select width N too small for R channels plus status");
  end

  logic [T-1:0]   hold_q [R];
  logic [R-1:0]   pending_vec;
  logic [R-1:0]   overrun_vec;
  logic [R-1:0]   rd_hit;
  logic [31:0]    sel_ext;
  sel_kind_e      sel_kind;
  logic [T-1:0]   chan_data;
  logic [R+T-1:0] status_ext;
  logic [T-1:0]   status_word;

  logic [T-1:0]   rd_data_d,  rd_data_q;
  logic           rd_valid_d, rd_valid_q;
  logic [R-1:0]   rd_ack_d,   rd_ack_q;
  logic           rd_err_d,   rd_err_q;

  assign sel_ext  = 32'(bus.rd_sel);
  assign sel_kind = decode_sel(sel_ext, R);

  // Zero-extend (or truncate when R > T) the pending vector to one word.
  assign status_ext  = {{T{1'b0}}, pending_vec};
  assign status_word = status_ext[T-1:0];

  always_comb begin
    rd_hit    = '0;
    chan_data = '0;
    for (int unsigned k = 0; k < R; k++) begin
      if (sel_ext == k) begin
        chan_data = hold_q[k];
        rd_hit[k] = bus.rd_req && (sel_kind == SEL_CHAN);
      end
    end
  end

  for (genvar k = 0; k < R; k++) begin : g_chan
    io_chan_hold #(.T(T)) u_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (bus.in_valid[k]),
      .data_in   (bus.data_in[k*T +: T]),
      .rd_hit    (rd_hit[k]),
      .hold_q    (hold_q[k]),
      .pending_q (pending_vec[k]),
      .overrun_q (overrun_vec[k])
    );
  end

  // Response decode; rd_data keeps its last value when idle.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_ack_d   = '0;
    rd_err_d   = 1'b0;
    if (bus.rd_req) begin
      rd_valid_d = 1'b1;
      unique case (sel_kind)
        SEL_CHAN: begin
          rd_data_d = chan_data;
          rd_ack_d  = rd_hit;
        end
        SEL_STATUS: begin
          rd_data_d = status_word;
        end
        default: begin
          rd_data_d = '0;
          rd_err_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_ack_q   <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_ack_q   <= rd_ack_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_ack   = rd_ack_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.pending  = pending_vec;
  assign bus.overrun  = overrun_vec;

endmodule
`default_nettype wire

// File: tb/tb_io_read_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_io_read_mux                                             |
// | Purpose : Directed self-checking bench for io_read_mux (R=4,T=8,N=3) |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_io_read_mux;

  localparam int unsigned R = 4;
  localparam int unsigned T = 8;
  localparam int unsigned N = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  io_read_mux_if #(.R(R), .T(T), .N(N)) bus ();

  io_read_mux #(.R(R), .T(T), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int k, input logic [7:0] v);
    bus.data_in[k*T +: T] = v;
  endtask

  task automatic read(input logic [2:0] sel);
    bus.rd_req = 1'b1;
    bus.rd_sel = sel;
  endtask

  task automatic idle();
    bus.rd_req   = 1'b0;
    bus.in_valid = '0;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.data_in  = '0;
    bus.in_valid = '0;
    bus.rd_req   = 1'b0;
    bus.rd_sel   = '0;
    tick();
    tick();

    // Reset state
    check("rst_rd_data",  32'(bus.rd_data),  32'h00);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    check("rst_rd_ack",   32'(bus.rd_ack),   32'h0);
    check("rst_rd_err",   32'(bus.rd_err),   32'h0);
    check("rst_pending",  32'(bus.pending),  32'h0);
    check("rst_overrun",  32'(bus.overrun),  32'h0);
    rst_n = 1'b1;
    tick();

    // Capture channel 2 then read it
    set_slice(2, 8'h5A);
    bus.in_valid = 4'b0100;
    tick();
    idle();
    check("cap2_pending", 32'(bus.pending), 32'b0100);
    read(3'd2);
    tick();
    idle();
    check("rd2_data",    32'(bus.rd_data),  32'h5A);
    check("rd2_valid",   32'(bus.rd_valid), 32'h1);
    check("rd2_ack",     32'(bus.rd_ack),   32'b0100);
    check("rd2_err",     32'(bus.rd_err),   32'h0);
    check("rd2_pending", 32'(bus.pending),  32'b0000);
    tick();
    check("idle_valid", 32'(bus.rd_valid), 32'h0);
    check("idle_ack",   32'(bus.rd_ack),   32'h0);
    check("idle_hold",  32'(bus.rd_data),  32'h5A);

    // Overrun on channel 1
    set_slice(1, 8'h11);
    bus.in_valid = 4'b0010;
    tick();
    check("ovr_first", 32'(bus.overrun), 32'b0000);
    set_slice(1, 8'h22);
    tick();
    idle();
    check("ovr_set",     32'(bus.overrun), 32'b0010);
    check("ovr_pending", 32'(bus.pending), 32'b0010);
    read(3'd1);
    tick();
    idle();
    check("rd1_data",    32'(bus.rd_data), 32'h22);
    check("rd1_ack",     32'(bus.rd_ack),  32'b0010);
    check("rd1_overrun", 32'(bus.overrun), 32'b0000);
    check("rd1_pending", 32'(bus.pending), 32'b0000);

    // Status word with pending = 1010
    set_slice(1, 8'hB1);
    set_slice(3, 8'hB3);
    bus.in_valid = 4'b1010;
    tick();
    idle();
    check("st_pending_pre", 32'(bus.pending), 32'b1010);
    read(3'd4);
    tick();
    idle();
    check("st_data",    32'(bus.rd_data),  32'h0A);
    check("st_valid",   32'(bus.rd_valid), 32'h1);
    check("st_ack",     32'(bus.rd_ack),   32'h0);
    check("st_err",     32'(bus.rd_err),   32'h0);
    check("st_pending", 32'(bus.pending),  32'b1010);

    // Invalid addresses
    read(3'd6);
    tick();
    idle();
    check("inv6_data",    32'(bus.rd_data),  32'h00);
    check("inv6_valid",   32'(bus.rd_valid), 32'h1);
    check("inv6_err",     32'(bus.rd_err),   32'h1);
    check("inv6_ack",     32'(bus.rd_ack),   32'h0);
    check("inv6_pending", 32'(bus.pending),  32'b1010);
    read(3'd5);
    tick();
    idle();
    check("inv5_err", 32'(bus.rd_err), 32'h1);
    tick();
    check("err_clear", 32'(bus.rd_err), 32'h0);

    // Same-cycle read and capture on channel 3
    set_slice(3, 8'h33);
    bus.in_valid = 4'b1000;
    tick();
    idle();
    check("c3_overrun", 32'(bus.overrun), 32'b1000);
    set_slice(3, 8'h44);
    bus.in_valid = 4'b1000;
    read(3'd3);
    tick();
    idle();
    check("same_data",    32'(bus.rd_data), 32'h33);
    check("same_pending", 32'(bus.pending), 32'b1010);
    check("same_overrun", 32'(bus.overrun), 32'b0000);
    read(3'd3);
    tick();
    idle();
    check("c3_new_data", 32'(bus.rd_data), 32'h44);
    check("c3_pending",  32'(bus.pending), 32'b0010);

    // Reading a channel with nothing pending still acknowledges
    read(3'd3);
    tick();
    idle();
    check("nopend_data", 32'(bus.rd_data), 32'h44);
    check("nopend_ack",  32'(bus.rd_ack),  32'b1000);
    check("nopend_err",  32'(bus.rd_err),  32'h0);

    // Back-to-back reads, reset mid-sequence
    read(3'd0);
    tick();
    check("b2b0_valid", 32'(bus.rd_valid), 32'h1);
    check("b2b0_ack",   32'(bus.rd_ack),   32'b0001);
    check("b2b0_data",  32'(bus.rd_data),  32'h00);
    read(3'd1);
    tick();
    check("b2b1_valid", 32'(bus.rd_valid), 32'h1);
    check("b2b1_ack",   32'(bus.rd_ack),   32'b0010);
    check("b2b1_data",  32'(bus.rd_data),  32'hB1);
    read(3'd2);
    tick();
    check("b2b2_valid", 32'(bus.rd_valid), 32'h1);
    check("b2b2_ack",   32'(bus.rd_ack),   32'b0100);
    check("b2b2_data",  32'(bus.rd_data),  32'h5A);
    read(3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data",    32'(bus.rd_data),  32'h00);
    check("arst_valid",   32'(bus.rd_valid), 32'h0);
    check("arst_ack",     32'(bus.rd_ack),   32'h0);
    check("arst_pending", 32'(bus.pending),  32'h0);
    check("arst_overrun", 32'(bus.overrun),  32'h0);
    tick();
    check("arst_edge_valid", 32'(bus.rd_valid), 32'h0);
    idle();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", 32'(bus.rd_valid), 32'h0);

    // First edge after release works normally
    set_slice(0, 8'h77);
    bus.in_valid = 4'b0001;
    read(3'd0);
    tick();
    idle();
    check("post_rd_valid", 32'(bus.rd_valid), 32'h1);
    check("post_rd_data",  32'(bus.rd_data),  32'h00);
    check("post_pending",  32'(bus.pending),  32'b0001);
    read(3'd0);
    tick();
    idle();
    check("post_rd0_data", 32'(bus.rd_data), 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_read_mux.md
IO_READ_MUX -- requirements
Module: io_read_mux

Interface
REQ-001 Parameter R, default 4: number of input channels, R >= 1.
REQ-002 Parameter T, default 8: bits per channel.
REQ-003 Parameter N, default 3: select width; N SHALL satisfy 2^N >= R+1 (elaboration-time check).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 data_in  in  R*T  channel k occupies bits [k*T+T-1 : k*T]; channel 0 in LSBs.
REQ-007 in_valid  in  R  bit k, one-cycle pulse: channel k data_in slice is new.
REQ-008 rd_req  in  1  read strobe, one cycle per read.
REQ-009 rd_sel  in  N  read address: 0..R-1 channel, R status word, >R invalid.
REQ-010 rd_data  out  T  read result, registered.
REQ-011 rd_valid  out  1  one-cycle pulse qualifying rd_data.
REQ-012 rd_ack  out  R  one-hot pulse: channel k consumed.
REQ-013 rd_err  out  1  one-cycle pulse: invalid address read.
REQ-014 pending  out  R  sticky per-channel unread-data flags.
REQ-015 overrun  out  R  sticky per-channel data-lost flags.

Function
REQ-016 On in_valid[k]=1 the module SHALL capture data_in slice k into hold register k on that edge.
REQ-017 in_valid[k]=1 SHALL set pending[k]; if pending[k] was already 1 and not cleared that cycle, overrun[k] SHALL also set.
REQ-018 rd_req=1 with rd_sel=k<R SHALL, one cycle later, drive rd_data=hold[k], rd_valid=1, rd_ack[k]=1; pending[k] and overrun[k] SHALL clear.
REQ-019 Same-cycle read of k and in_valid[k]: rd_data returns the old hold[k]; hold[k] takes the new value; pending[k] stays 1 (set wins); overrun[k] clears.
REQ-020 rd_sel=R SHALL, one cycle later, return rd_data={pending} zero-extended to T (truncated to T LSBs if R>T), rd_valid=1, no rd_ack, no flag change.
REQ-021 rd_sel>R SHALL, one cycle later, return rd_data=0, rd_valid=1, rd_err=1, no flag change.
REQ-022 Read latency SHALL be exactly 1 cycle; rd_req accepted every cycle, back-to-back, no stall.
REQ-023 With rd_req=0: rd_valid, rd_ack and rd_err SHALL be 0; rd_data SHALL hold its last value.
REQ-024 Reading a channel with pending=0 SHALL still return hold[k], pulse rd_valid and rd_ack[k]; no error.
REQ-025 in_valid bits SHALL be processed independently; any combination may assert in one cycle.

Reset
REQ-026 rst_n=0 SHALL asynchronously force all hold registers, pending, overrun, rd_data to 0 and all pulses to 0.
REQ-027 A read requested in the cycle reset asserts SHALL be discarded; no rd_valid after release.
REQ-028 After rst_n deasserts, first edge SHALL accept rd_req and in_valid normally.

Structure
REQ-029 Address decode constants (status address = R) and the N >= clog2(R+1) check SHALL live in shared package io_pkg.
REQ-030 One sub-module io_chan_hold (hold register, pending, overrun for one channel), instantiated R times via generate.
REQ-031 Output mux and decode SHALL be combinational feeding a single output register stage.

Verification (R=4, T=8, N=3)
REQ-032 Reset, in_valid[2] with slice 2=0x5A, then read sel=2 -> next cycle rd_data=0x5A, rd_valid=1, rd_ack=0100, pending=0000.
REQ-033 Two in_valid[1] pulses (0x11 then 0x22), no read -> overrun[1]=1; read sel=1 -> rd_data=0x22, overrun[1]=0.
REQ-034 pending=1010, read sel=4 -> rd_data=0x0A, no rd_ack, pending unchanged.
REQ-035 Read sel=6 -> rd_data=0x00, rd_valid=1, rd_err=1, flags unchanged.
REQ-036 hold[3]=0x33 pending, same cycle read sel=3 and in_valid[3] with 0x44 -> rd_data=0x33, pending[3]=1; next read sel=3 -> 0x44.
REQ-037 Back-to-back reads sel=0,1,2,3 on consecutive cycles -> four consecutive rd_valid pulses, rd_ack 0001,0010,0100,1000; rst_n pulsed low mid-sequence -> all outputs 0 immediately.
